// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - fetch-to-decode instruction handshake
interface instruction_fetch_queue_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;

  modport master (output inst_valid, output inst_data, output inst_pc, input inst_ready);
  modport slave  (input inst_valid, input inst_data, input inst_pc, output inst_ready);
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - LEGv8 fetch PC, ROM addressing and prefetch FIFO
module instruction_fetch_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                             clock,
  input  logic                             reset_n,
  output logic [15:0]                      rom_address,
  input  logic [31:0]                      rom_data,
  instruction_fetch_queue_if.master        inst,
  input  logic                             redirect_valid,
  input  logic [63:0]                      redirect_pc,
  output logic [31:0]                      fetch_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   mem_data [DEPTH];
  logic [63:0]   mem_pc   [DEPTH];
  logic          not_empty;
  logic          pop;
  logic          push;

  assign not_empty   = (count != '0);
  assign rom_address = fetch_pc[17:2];

  // A redirect hides the head so decode cannot consume a soon-to-be-flushed entry.
  assign inst.inst_valid = not_empty & ~redirect_valid;
  assign inst.inst_data  = not_empty ? mem_data[rd_ptr] : 32'h0;
  assign inst.inst_pc    = not_empty ? mem_pc[rd_ptr]   : 64'h0;

  assign pop  = inst.inst_valid & inst.inst_ready & ~redirect_valid;
  assign push = ~redirect_valid & ((count < FULL) | pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fetch_count <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~64'h3;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc    <= fetch_pc + 64'd4;
        fetch_count <= fetch_count + 32'd1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb/tb_instruction_fetch_queue.sv - scoreboard bench for instruction_fetch_queue
module tb_instruction_fetch_queue;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] rom_address;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic [31:0] fetch_count;
  int          checks = 0;
  int          errors = 0;
  logic [95:0] exp_q [$];

  instruction_fetch_queue_if ifc ();

  instruction_fetch_queue #(.DEPTH(2), .RESET_PC(64'h0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .inst           (ifc.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_count    (fetch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    case (a)
      16'd0:   rom_word = 32'hD2800021;
      16'd1:   rom_word = 32'hD2800042;
      16'd2:   rom_word = 32'h8B020024;
      16'd16:  rom_word = 32'h91000421;
      default: rom_word = {16'hA5A5, a};
    endcase
  endfunction

  assign rom_data = rom_word(rom_address);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [63:0] pc);
    exp_q.push_back({pc, rom_word(pc[17:2])});
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    ifc.inst_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_valid", {63'h0, ifc.inst_valid}, 64'h0);
    chk("rst_data", {32'h0, ifc.inst_data}, 64'h0);
    chk("rst_pc", ifc.inst_pc, 64'h0);
    chk("rst_count", {32'h0, fetch_count}, 64'h0);
    chk("rst_romaddr", {48'h0, rom_address}, 64'h0);
    step(1);
    reset_n = 1'b1;
  endtask

  // Monitor: every handshake seen at the falling edge fires on the next rising edge.
  always @(negedge clock) begin
    if (reset_n && ifc.inst_valid && ifc.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake actual pc %0h required none", ifc.inst_pc);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("hs_pc", ifc.inst_pc, e[95:32]);
        chk("hs_data", {32'h0, ifc.inst_data}, {32'h0, e[31:0]});
      end
    end
  end

  initial begin
    ifc.inst_ready = 1'b0;

    // Basic streaming from reset
    do_reset();
    ifc.inst_ready = 1'b1;
    expect_entry(64'h0);
    expect_entry(64'h4);
    expect_entry(64'h8);
    step(1);
    chk("a_valid_edge1", {63'h0, ifc.inst_valid}, 64'h1);
    step(2);
    chk("a_fetch_count3", {32'h0, fetch_count}, 64'd3);
    step(1);
    ifc.inst_ready = 1'b0;
    chk("a_drain", exp_q.size(), 64'd0);

    // Backpressure then release
    do_reset();
    step(5);
    chk("b_romaddr", {48'h0, rom_address}, 64'd2);
    chk("b_head_pc", ifc.inst_pc, 64'h0);
    chk("b_fetch_count", {32'h0, fetch_count}, 64'd2);
    expect_entry(64'h0);
    expect_entry(64'h4);
    expect_entry(64'h8);
    ifc.inst_ready = 1'b1;
    step(3);
    ifc.inst_ready = 1'b0;
    chk("b_drain", exp_q.size(), 64'd0);

    // Full FIFO, simultaneous push and pop
    for (int k = 0; k < 10; k++) expect_entry(64'd12 + 64'(4 * k));
    ifc.inst_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("c_head_pc", ifc.inst_pc, 64'd12 + 64'(4 * k));
      chk("c_romaddr", {48'h0, rom_address}, 64'd5 + 64'(k));
    end
    ifc.inst_ready = 1'b0;
    chk("c_drain", exp_q.size(), 64'd0);
    chk("c_fetch_count", {32'h0, fetch_count}, 64'd15);

    // Redirect while two entries are queued
    ifc.inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h40;
    #1;
    chk("d_valid_masked", {63'h0, ifc.inst_valid}, 64'h0);
    step(1);
    redirect_valid = 1'b0;
    ifc.inst_ready = 1'b0;
    chk("d_flushed", {63'h0, ifc.inst_valid}, 64'h0);
    step(1);
    chk("d_valid", {63'h0, ifc.inst_valid}, 64'h1);
    chk("d_pc", ifc.inst_pc, 64'h40);
    chk("d_data", {32'h0, ifc.inst_data}, 64'h91000421);
    chk("d_fetch_count", {32'h0, fetch_count}, 64'd16);

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 64'h23;
    step(1);
    redirect_valid = 1'b0;
    chk("e_romaddr", {48'h0, rom_address}, 64'd8);
    expect_entry(64'h20);
    ifc.inst_ready = 1'b1;
    step(2);
    ifc.inst_ready = 1'b0;
    chk("e_drain", exp_q.size(), 64'd0);

    // Reset pulsed mid-stream after seven fetches
    do_reset();
    ifc.inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) expect_entry(64'(4 * k));
    step(7);
    chk("f_fetch_count7", {32'h0, fetch_count}, 64'd7);
    reset_n = 1'b0;
    #1;
    chk("f_async_valid", {63'h0, ifc.inst_valid}, 64'h0);
    chk("f_async_pc", ifc.inst_pc, 64'h0);
    chk("f_async_data", {32'h0, ifc.inst_data}, 64'h0);
    chk("f_async_count", {32'h0, fetch_count}, 64'h0);
    chk("f_drain", exp_q.size(), 64'd0);
    step(1);
    reset_n = 1'b1;
    expect_entry(64'h0);
    step(1);
    chk("f_first_pc", ifc.inst_pc, 64'h0);
    step(1);
    ifc.inst_ready = 1'b0;
    chk("f_final_drain", exp_q.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1);
  end
endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Fetch stage of the LEGv8 single-issue core; sits between the PC/branch logic and decode.
- Owns the fetch PC and drives the word address of the combinational instruction ROM (rom_case).
- Captures each returned 32-bit instruction, with its PC, into a small prefetch FIFO and presents it to decode over a valid/ready handshake.
- Accepts branch redirects (B, BL, CBZ/CBNZ, B.cond, BR) from execute and flushes stale entries.

Parameters:
- DEPTH, 2, FIFO entries; power of two, minimum 2.
- RESET_PC, 64'h0, byte address loaded into the fetch PC at reset.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- rom_address  output  16  word address to the ROM; equals fetch_pc[17:2].
- rom_data  input  32  instruction from the ROM, valid combinationally in the same cycle.
- inst_valid  output  1  head FIFO entry is available to decode.
- inst_ready  input  1  decode accepts the head entry this cycle.
- inst_data  output  32  head instruction.
- inst_pc  output  64  byte address of the head instruction.
- redirect_valid  input  1  execute requests a PC change.
- redirect_pc  input  64  new byte target; bits [1:0] are ignored (treated as 0).
- fetch_count  output  32  number of instructions pushed since reset.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FIFO empty (rd/wr pointers 0, count 0).
  - inst_valid = 0; inst_data = 0; inst_pc = 0; fetch_count = 0.
- Definitions:
  - pop = inst_valid & inst_ready & ~redirect_valid.
  - push = ~redirect_valid & (count < DEPTH | pop).
- On a push edge:
  - Write {fetch_pc, rom_data} at wr_ptr.
  - fetch_pc += 4; fetch_count += 1.
- Priority is redirect > pop/push:
  - redirect_valid=1 at an edge flushes the FIFO: count=0, pointers=0, fetch_pc = {redirect_pc[63:2],2'b00}.
  - No push or pop occurs on that edge.
- While redirect_valid is high, inst_valid is forced to 0 combinationally, so no handshake can fire.
- Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
- A pop on an empty FIFO cannot occur, because inst_valid=0.
- inst_valid = (count != 0) & ~redirect_valid. inst_data and inst_pc show the head entry and are 0 when empty.
- Latency:
  - After reset release, the first edge pushes ROM[RESET_PC>>2]; inst_valid is high after that edge.
  - Redirect to valid target: 1 edge for the flush, 1 edge for the push, so inst_valid rises after the 2nd edge.
- Steady state with inst_ready held high: one instruction per cycle, no bubbles.
- With inst_ready low, the FIFO fills to DEPTH and then stops pushing. fetch_pc holds at the next unfetched address.
- Pointers are log2(DEPTH) bits and wrap naturally.
- fetch_pc wrap: a 64-bit add with wrap at 2^64. rom_address wraps at 16 bits, aliasing to ROM word 0.
- fetch_count wraps at 2^32.
- Asserting reset_n low mid-operation immediately clears all state, including a pending redirect.
- No internal halt detection: the ROM default (BR XZR, 32'hD60003E0) is fetched like any other instruction.

Test Plan:
- Reset release, inst_ready=1, ROM holds MOVZ X1,1 / MOVZ X2,2 / ADD X4,X1,X2:
  - inst_valid rises after edge 1.
  - Handshakes present (pc=0, 32'hD2800021), then (4, 32'hD2800042), then (8, 32'h8B020024) on consecutive cycles.
  - fetch_count = 3 after edge 3.
- Backpressure with inst_ready=0 for 5 cycles, DEPTH=2:
  - count saturates at 2; rom_address holds 2; inst_pc holds 0.
  - After raising ready, entries with pc 0, 4, 8 are accepted in order with no gaps.
- Redirect with redirect_valid=1, redirect_pc=64'h40 while 2 entries are queued and inst_ready=1:
  - inst_valid=0 in that cycle; no entry is consumed; FIFO is flushed.
  - After 2 edges, inst_pc=64'h40 and inst_data=ROM[16].
- Redirect with redirect_pc=64'h23 (misaligned): next fetched pc = 64'h20 and rom_address = 8.
- Full FIFO with simultaneous push and pop for 10 cycles: count stays 2 and inst_pc increments by 4 every cycle.
- reset_n pulsed low mid-stream after 7 fetches:
  - Outputs go to 0 asynchronously; fetch_count = 0.
  - After release, first inst_pc = RESET_PC.
